// File: rtl/bsg_fma_aux_adder_pipe_if.sv
// Operand, result and valid/ready bundle for bsg_fma_aux_adder_pipe.
// The slave side is the adder; the master side is its upstream/downstream neighbour.
interface bsg_fma_aux_adder_pipe_if #(parameter int unsigned width_p = 8);
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] a_l_i;
  logic [width_p-1:0] a_h_i;
  logic [width_p-1:0] b_l_i;
  logic [width_p-1:0] b_h_i;
  logic               acc_i;
  logic               v_o;
  logic               ready_i;
  logic [width_p-1:0] mod_o;

  modport slave (
    input  v_i, a_l_i, a_h_i, b_l_i, b_h_i, acc_i, ready_i,
    output ready_o, v_o, mod_o
  );

  modport master (
    output v_i, a_l_i, a_h_i, b_l_i, b_h_i, acc_i, ready_i,
    input  ready_o, v_o, mod_o
  );
endinterface

// File: rtl/bsg_fma_aux_adder_pipe.sv
// Two-stage cross-term adder: (a_h*b_l + a_l*b_h [+ previous result]) mod 2^width_p,
// with valid/ready back-pressure and two transactions of buffering.
module bsg_fma_aux_adder_pipe #(
  parameter int unsigned width_p = 8
) (
  input logic                     clk_i,
  input logic                     reset_i,
  bsg_fma_aux_adder_pipe_if.slave io
);
  localparam int unsigned W    = width_p;
  localparam int unsigned ROWS = 2 * width_p;

  logic [W-1:0] w_rows [ROWS];
  logic [W-1:0] w_sum;
  logic [W-1:0] w_car;
  logic [W-1:0] w_maj;
  logic [W-1:0] w_s2_sum;
  logic         w_in_fire;
  logic         w_s2_load;

  logic         r_s1_v;
  logic         r_acc;
  logic [W-1:0] r_csa_a;
  logic [W-1:0] r_csa_b;
  logic         r_s2_v;
  logic [W-1:0] r_mod;

  // Partial-product rows, each truncated to the result width.
  always_comb begin
    for (int unsigned i = 0; i < W; i++) begin
      w_rows[i]     = (io.a_h_i & {W{io.b_l_i[i]}}) << i;
      w_rows[W + i] = (io.a_l_i & {W{io.b_h_i[i]}}) << i;
    end
  end

  // Carry-save reduction of all rows down to a sum/carry pair.
  always_comb begin
    w_sum = '0;
    w_car = '0;
    w_maj = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      w_maj = (w_sum & w_car) | (w_sum & w_rows[r]) | (w_car & w_rows[r]);
      w_sum = w_sum ^ w_car ^ w_rows[r];
      w_car = w_maj << 1;
    end
  end

  assign w_in_fire  = io.v_i & io.ready_o;
  assign w_s2_load  = r_s1_v & (~r_s2_v | io.ready_i);
  assign io.ready_o = ~r_s1_v | w_s2_load;

  // r_mod doubles as the accumulator, so a chained input sees the result loaded one edge earlier.
  assign w_s2_sum = r_csa_a + r_csa_b + (r_acc ? r_mod : W'(0));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1_v  <= 1'b0;
      r_acc   <= 1'b0;
      r_csa_a <= '0;
      r_csa_b <= '0;
    end else if (w_in_fire) begin
      r_s1_v  <= 1'b1;
      r_acc   <= io.acc_i;
      r_csa_a <= w_sum;
      r_csa_b <= w_car;
    end else if (w_s2_load) begin
      r_s1_v  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s2_v <= 1'b0;
      r_mod  <= '0;
    end else if (w_s2_load) begin
      r_s2_v <= 1'b1;
      r_mod  <= w_s2_sum;
    end else if (r_s2_v & io.ready_i) begin
      r_s2_v <= 1'b0;
    end
  end

  assign io.v_o   = r_s2_v;
  assign io.mod_o = r_mod;
endmodule
